// File: rtl/ultrasonic_burst_gen.sv
// Complementary square-wave transducer driver: N-period burst or continuous tone, start/busy/done handshake.
// Start-to-tx latency 1 cycle; no backpressure, enable_i=0 freezes all state in place.
module ultrasonic_burst_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic               stop_i,
    input  logic [CNT_W-1:0]   half_period_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               tx_p_o,
    output logic               tx_n_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W-1:0] period_cnt_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PH_HI = 2'd1;
    localparam logic [1:0] S_PH_LO = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic               mode_q, mode_d;
    logic [BURST_W-1:0] burst_len_q, burst_len_d;
    logic [BURST_W-1:0] period_cnt_q, period_cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic               done_q, done_d;

    logic               busy;
    logic               phase_end;
    logic [BURST_W-1:0] period_inc;

    assign busy       = (state_q != S_IDLE);
    assign phase_end  = (half_cnt_q == (h_q - CNT_W'(1)));
    assign period_inc = period_cnt_q + BURST_W'(1);

    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        h_d          = h_q;
        mode_d       = mode_q;
        burst_len_d  = burst_len_q;
        period_cnt_d = period_cnt_q;
        done_d       = 1'b0;
        // A stop request is captured even while frozen so it is never lost.
        stop_pend_d  = stop_pend_q | (stop_i & busy);

        if (enable_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        h_d          = (half_period_i < CNT_W'(2)) ? CNT_W'(2) : half_period_i;
                        mode_d       = mode_i;
                        burst_len_d  = burst_len_i;
                        period_cnt_d = '0;
                        half_cnt_d   = '0;
                        if (!mode_i && (burst_len_i == '0)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_PH_HI;
                        end
                    end
                end
                S_PH_HI: begin
                    if (phase_end) begin
                        half_cnt_d = '0;
                        state_d    = S_PH_LO;
                    end else begin
                        half_cnt_d = half_cnt_q + CNT_W'(1);
                    end
                end
                S_PH_LO: begin
                    if (phase_end) begin
                        half_cnt_d   = '0;
                        period_cnt_d = period_inc;
                        if ((!mode_q && (period_inc == burst_len_q)) || stop_pend_q) begin
                            state_d     = S_IDLE;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            state_d = S_PH_HI;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    half_cnt_d  = '0;
                    stop_pend_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            half_cnt_q   <= '0;
            h_q          <= CNT_W'(2);
            mode_q       <= 1'b0;
            burst_len_q  <= '0;
            period_cnt_q <= '0;
            stop_pend_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            h_q          <= h_d;
            mode_q       <= mode_d;
            burst_len_q  <= burst_len_d;
            period_cnt_q <= period_cnt_d;
            stop_pend_q  <= stop_pend_d;
            done_q       <= done_d;
        end
    end

    assign tx_p_o       = (state_q == S_PH_HI);
    assign tx_n_o       = (state_q == S_PH_LO);
    assign busy_o       = busy;
    // A pulse that lands in a frozen cycle is dropped rather than stretched.
    assign done_o       = done_q & enable_i;
    assign period_cnt_o = period_cnt_q;

endmodule

// File: tb/tb_ultrasonic_burst_gen.sv
// Directed bench for ultrasonic_burst_gen: cycle-by-cycle expected waveforms derived by hand.
// "Cycle c" is the clock period following the c-th rising edge after start is sampled (edge 0).
module tb_ultrasonic_burst_gen;

    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               enable_i;
    logic               start_i;
    logic               mode_i;
    logic               stop_i;
    logic [CNT_W-1:0]   half_period_i;
    logic [BURST_W-1:0] burst_len_i;
    logic               tx_p_o;
    logic               tx_n_o;
    logic               busy_o;
    logic               done_o;
    logic [BURST_W-1:0] period_cnt_o;

    int errors = 0;
    int checks = 0;

    ultrasonic_burst_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .stop_i        (stop_i),
        .half_period_i (half_period_i),
        .burst_len_i   (burst_len_i),
        .tx_p_o        (tx_p_o),
        .tx_n_o        (tx_n_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .period_cnt_o  (period_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        start_i = 1'b0;
        stop_i  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        rst_i = 1'b1; enable_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; stop_i = 1'b0;
        half_period_i = 16'd4; burst_len_i = 8'd3;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        checks++; if (tx_p_o !== 1'b0) begin errors++; $display("FAIL reset tx_p: got %b want 0", tx_p_o); end
        checks++; if (tx_n_o !== 1'b0) begin errors++; $display("FAIL reset tx_n: got %b want 0", tx_n_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done_o); end
        checks++; if (period_cnt_o !== 8'd0) begin errors++; $display("FAIL reset period_cnt: got %0d want 0", period_cnt_o); end
        enable_i = 1'b0; start_i = 1'b1;
        tick(); tick();
        checks++; if (busy_o !== 1'b0 || tx_p_o !== 1'b0 || done_o !== 1'b0)
            begin errors++; $display("FAIL disabled_start: got busy=%b tx_p=%b done=%b want 0 0 0", busy_o, tx_p_o, done_o); end
        start_i = 1'b0; enable_i = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_burst;
        logic exp_p, exp_n, exp_b, exp_d;
        int   exp_pc;
        half_period_i = 16'd4; burst_len_i = 8'd3; mode_i = 1'b0; start_i = 1'b1;
        tick();
        for (int c = 1; c <= 26; c++) begin
            start_i = 1'b0;
            // Mid-run input changes must be ignored until the next start.
            half_period_i = 16'd7; burst_len_i = 8'd9; mode_i = 1'b1;
            #1;
            exp_b  = (c <= 24);
            exp_p  = exp_b && (((c - 1) / 4) % 2 == 0);
            exp_n  = exp_b && !exp_p;
            exp_d  = (c == 25);
            exp_pc = ((c - 1) / 8 > 3) ? 3 : (c - 1) / 8;
            checks++; if (tx_p_o !== exp_p) begin errors++; $display("FAIL burst tx_p c%0d: got %b want %b", c, tx_p_o, exp_p); end
            checks++; if (tx_n_o !== exp_n) begin errors++; $display("FAIL burst tx_n c%0d: got %b want %b", c, tx_n_o, exp_n); end
            checks++; if (busy_o !== exp_b) begin errors++; $display("FAIL burst busy c%0d: got %b want %b", c, busy_o, exp_b); end
            checks++; if (done_o !== exp_d) begin errors++; $display("FAIL burst done c%0d: got %b want %b", c, done_o, exp_d); end
            checks++; if (period_cnt_o !== exp_pc[7:0]) begin errors++; $display("FAIL burst period_cnt c%0d: got %0d want %0d", c, period_cnt_o, exp_pc); end
            tick();
        end
        mode_i = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_clamp_zero;
        logic exp_p, exp_n, exp_b, exp_d;
        half_period_i = 16'd1; burst_len_i = 8'd1; mode_i = 1'b0; start_i = 1'b1;
        tick();
        for (int c = 1; c <= 6; c++) begin
            start_i = 1'b0;
            #1;
            exp_p = (c <= 2);
            exp_n = (c == 3 || c == 4);
            exp_b = (c <= 4);
            exp_d = (c == 5);
            checks++; if (tx_p_o !== exp_p) begin errors++; $display("FAIL clamp tx_p c%0d: got %b want %b", c, tx_p_o, exp_p); end
            checks++; if (tx_n_o !== exp_n) begin errors++; $display("FAIL clamp tx_n c%0d: got %b want %b", c, tx_n_o, exp_n); end
            checks++; if (busy_o !== exp_b) begin errors++; $display("FAIL clamp busy c%0d: got %b want %b", c, busy_o, exp_b); end
            checks++; if (done_o !== exp_d) begin errors++; $display("FAIL clamp done c%0d: got %b want %b", c, done_o, exp_d); end
            tick();
        end
        checks++; if (period_cnt_o !== 8'd1) begin errors++; $display("FAIL clamp period_cnt: got %0d want 1", period_cnt_o); end
        half_period_i = 16'd4; burst_len_i = 8'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        #1;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zero_len done: got %b want 1", done_o); end
        checks++; if (busy_o !== 1'b0 || tx_p_o !== 1'b0 || tx_n_o !== 1'b0)
            begin errors++; $display("FAIL zero_len idle: got busy=%b tx_p=%b tx_n=%b want 0 0 0", busy_o, tx_p_o, tx_n_o); end
        checks++; if (period_cnt_o !== 8'd0) begin errors++; $display("FAIL zero_len period_cnt: got %0d want 0", period_cnt_o); end
        tick();
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0)
            begin errors++; $display("FAIL zero_len after: got done=%b busy=%b want 0 0", done_o, busy_o); end
        idle_cycles(2);
    endtask

    task automatic test_continuous_stop;
        logic exp_p, exp_n, exp_b, exp_d;
        // stop coinciding with start in IDLE must be ignored; burst_len=1 must not end a continuous run.
        half_period_i = 16'd3; burst_len_i = 8'd1; mode_i = 1'b1; start_i = 1'b1; stop_i = 1'b1;
        tick();
        for (int c = 1; c <= 14; c++) begin
            start_i = 1'b0;
            stop_i  = (c == 8);
            #1;
            exp_b = (c <= 12);
            exp_p = exp_b && (((c - 1) / 3) % 2 == 0);
            exp_n = exp_b && !exp_p;
            exp_d = (c == 13);
            checks++; if (tx_p_o !== exp_p) begin errors++; $display("FAIL cont tx_p c%0d: got %b want %b", c, tx_p_o, exp_p); end
            checks++; if (tx_n_o !== exp_n) begin errors++; $display("FAIL cont tx_n c%0d: got %b want %b", c, tx_n_o, exp_n); end
            checks++; if (busy_o !== exp_b) begin errors++; $display("FAIL cont busy c%0d: got %b want %b", c, busy_o, exp_b); end
            checks++; if (done_o !== exp_d) begin errors++; $display("FAIL cont done c%0d: got %b want %b", c, done_o, exp_d); end
            tick();
        end
        checks++; if (period_cnt_o !== 8'd2) begin errors++; $display("FAIL cont period_cnt: got %0d want 2", period_cnt_o); end
        mode_i = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_enable_freeze;
        logic exp_p, exp_n, exp_b, exp_d;
        // Variant 0: burst of 1. Variant 1: continuous, ended only by a stop issued while frozen.
        for (int v = 0; v < 2; v++) begin
            half_period_i = 16'd4; burst_len_i = 8'd1; mode_i = (v == 1); start_i = 1'b1;
            tick();
            for (int c = 1; c <= 14; c++) begin
                start_i  = 1'b0;
                enable_i = !(c >= 2 && c <= 5);
                stop_i   = (v == 1) && (c == 3);
                #1;
                exp_p = (c <= 8);
                exp_n = (c >= 9 && c <= 12);
                exp_b = (c <= 12);
                exp_d = (c == 13);
                checks++; if (tx_p_o !== exp_p) begin errors++; $display("FAIL freeze%0d tx_p c%0d: got %b want %b", v, c, tx_p_o, exp_p); end
                checks++; if (tx_n_o !== exp_n) begin errors++; $display("FAIL freeze%0d tx_n c%0d: got %b want %b", v, c, tx_n_o, exp_n); end
                checks++; if (busy_o !== exp_b) begin errors++; $display("FAIL freeze%0d busy c%0d: got %b want %b", v, c, busy_o, exp_b); end
                checks++; if (done_o !== exp_d) begin errors++; $display("FAIL freeze%0d done c%0d: got %b want %b", v, c, done_o, exp_d); end
                tick();
            end
            enable_i = 1'b1;
            checks++; if (period_cnt_o !== 8'd1) begin errors++; $display("FAIL freeze%0d period_cnt: got %0d want 1", v, period_cnt_o); end
            idle_cycles(2);
        end
        mode_i = 1'b0;
    endtask

    task automatic test_reset_midrun;
        logic seen;
        half_period_i = 16'd4; burst_len_i = 8'd3; mode_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 14; c++) tick();
        checks++; if (tx_n_o !== 1'b1 || period_cnt_o !== 8'd1)
            begin errors++; $display("FAIL midrun pre: got tx_n=%b period_cnt=%0d want 1 1", tx_n_o, period_cnt_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || tx_p_o !== 1'b0 || tx_n_o !== 1'b0)
            begin errors++; $display("FAIL midrun idle: got busy=%b tx_p=%b tx_n=%b want 0 0 0", busy_o, tx_p_o, tx_n_o); end
        checks++; if (period_cnt_o !== 8'd0) begin errors++; $display("FAIL midrun period_cnt: got %0d want 0", period_cnt_o); end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun no_done: got activity=%b want 0", seen); end
    endtask

    task automatic test_back_to_back;
        logic exp_p, exp_n, exp_b, exp_d;
        half_period_i = 16'd2; burst_len_i = 8'd1; mode_i = 1'b0; start_i = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            start_i = (c <= 5);
            #1;
            exp_p = (c == 1 || c == 2 || c == 6 || c == 7);
            exp_n = (c == 3 || c == 4 || c == 8 || c == 9);
            exp_b = exp_p || exp_n;
            exp_d = (c == 5 || c == 10);
            checks++; if (tx_p_o !== exp_p) begin errors++; $display("FAIL b2b tx_p c%0d: got %b want %b", c, tx_p_o, exp_p); end
            checks++; if (tx_n_o !== exp_n) begin errors++; $display("FAIL b2b tx_n c%0d: got %b want %b", c, tx_n_o, exp_n); end
            checks++; if (busy_o !== exp_b) begin errors++; $display("FAIL b2b busy c%0d: got %b want %b", c, busy_o, exp_b); end
            checks++; if (done_o !== exp_d) begin errors++; $display("FAIL b2b done c%0d: got %b want %b", c, done_o, exp_d); end
            if (c == 6) begin
                checks++; if (period_cnt_o !== 8'd0) begin errors++; $display("FAIL b2b period_cnt restart: got %0d want 0", period_cnt_o); end
            end
            tick();
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_clamp_zero();
        test_continuous_stop();
        test_enable_freeze();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
